// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipe_ctrl_v2 pipeline controller.
// Holds the opcode map, ALU/ImmSrc/ResultSrc encodings, the stage payload
// structs and the branch-condition helper used in E.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // D->E payload. ALU control is carried at its 4-bit native width and
  // zero-extended at the output port.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       pc_target_src;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_w_t;

  // Branch condition selected by the funct3 carried into E. The 010/011
  // codes never reach here as branches (decoded illegal, Branch forced 0).
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = !zero;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// D-stage decoder for pipe_ctrl_v2. Purely combinational.
// Ports:
//   op, funct3, funct7b5 : instruction fields in D
//   ctrl                 : control payload loaded into the E register
//   imm_src              : immediate format for the D-stage extender
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
#(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output ctrl_e_t    ctrl,
  output logic [2:0] imm_src
);

  alu_op_t alu_op;
  logic    legal;

  // ALU op for R-type and I-type ALU instructions. Bit 30 selects sub only
  // for R-type (it is part of the immediate for addi) but selects sra for
  // both R-type and srai.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (funct7b5 && (op == OP_RTYPE)) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.funct3 = funct3;
    imm_src     = IMM_I;
    legal       = 1'b1;
    case (op)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src_b  = 1'b1;
        legal           = (funct3 == 3'b010);
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_S;
        legal          = (funct3 == 3'b010);
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_op;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = alu_op;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        imm_src       = IMM_B;
        legal         = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.jump          = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.result_src    = RES_PC4;
        ctrl.alu_src_b     = 1'b1;
        ctrl.pc_target_src = 1'b1;
        legal              = EN_JALR;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
        imm_src        = IMM_U;
        legal          = EN_UPPER;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_U;
        legal          = EN_UPPER;
      end
      default: legal = 1'b0;
    endcase

    // An illegal instruction may not change architectural state or redirect
    // fetch; the remaining fields flow through as decoded.
    if (!legal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl_v2.sv
// 5-stage RV32I pipeline controller: decodes in D and carries control
// through the D->E, E->M and M->W registers.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   op/funct3/funct7b5    : D-stage instruction fields
//   ZeroE/LtE/LtuE        : ALU flags for branch resolution in E
//   StallE/FlushE         : hazard-unit hold / bubble for the E stage
//   ImmSrcD               : D-stage immediate format
//   *E outputs            : E-stage ALU/operand/redirect controls
//   *M outputs            : M-stage write enables and access size
//   *W outputs            : W-stage result select, write enable, illegal
//   IllegalSeen           : sticky, set once an illegal instruction retires
module pipe_ctrl_v2
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUC_W   = 4,
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              ZeroE,
  input  logic              LtE,
  input  logic              LtuE,
  input  logic              StallE,
  input  logic              FlushE,
  output logic [2:0]        ImmSrcD,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic              PCSrcE,
  output logic              PCTargetSrcE,
  output logic              ResultSrcE0,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [2:0]        Funct3M,
  output logic [1:0]        ResultSrcW,
  output logic              RegWriteW,
  output logic              IllegalW,
  output logic              IllegalSeen
);

  ctrl_e_t ctrl_d;
  ctrl_e_t ctrl_e;
  ctrl_m_t ctrl_m;
  ctrl_m_t m_next;
  ctrl_w_t ctrl_w;
  logic    illegal_seen;

  pipe_ctrl_dec #(
    .EN_JALR (EN_JALR),
    .EN_UPPER(EN_UPPER)
  ) u_dec (
    .op      (op),
    .funct3  (funct3),
    .funct7b5(funct7b5),
    .ctrl    (ctrl_d),
    .imm_src (ImmSrcD)
  );

  // Flush wins over stall: E takes the bubble and the instruction that was
  // in E moves on to M.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_e <= '0;
    end else if (FlushE) begin
      ctrl_e <= '0;
    end else if (!StallE) begin
      ctrl_e <= ctrl_d;
    end
  end

  // While E is held, M must not see the held instruction twice.
  always_comb begin
    m_next = '0;
    if (!(StallE && !FlushE)) begin
      m_next.reg_write  = ctrl_e.reg_write;
      m_next.mem_write  = ctrl_e.mem_write;
      m_next.result_src = ctrl_e.result_src;
      m_next.funct3     = ctrl_e.funct3;
      m_next.illegal    = ctrl_e.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_m <= m_next;
      ctrl_w <= '{reg_write:  ctrl_m.reg_write,
                  result_src: ctrl_m.result_src,
                  illegal:    ctrl_m.illegal};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_seen <= 1'b0;
    end else if (ctrl_w.illegal) begin
      illegal_seen <= 1'b1;
    end
  end

  assign ALUControlE  = ALUC_W'(ctrl_e.alu_ctrl);
  assign ALUSrcAE     = ctrl_e.alu_src_a;
  assign ALUSrcBE     = ctrl_e.alu_src_b;
  assign PCTargetSrcE = ctrl_e.pc_target_src;
  assign ResultSrcE0  = ctrl_e.result_src[0];
  // A bubble has branch = jump = 0, so PCSrcE is quiet for it.
  assign PCSrcE       = (ctrl_e.branch & branch_taken(ctrl_e.funct3, ZeroE, LtE, LtuE))
                        | ctrl_e.jump;
  assign RegWriteM    = ctrl_m.reg_write;
  assign MemWriteM    = ctrl_m.mem_write;
  assign Funct3M      = ctrl_m.funct3;
  assign ResultSrcW   = ctrl_w.result_src;
  assign RegWriteW    = ctrl_w.reg_write;
  assign IllegalW     = ctrl_w.illegal;
  assign IllegalSeen  = illegal_seen;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
module tb_pipe_ctrl_v2;

  localparam logic [6:0] NOP_OP = 7'b0010011;

  logic       clk = 1'b0;
  logic       reset, funct7b5, ZeroE, LtE, LtuE, StallE, FlushE;
  logic [6:0] op;
  logic [2:0] funct3;

  logic [2:0] a_imm, b_imm, a_f3m, b_f3m;
  logic [3:0] a_alu, b_alu;
  logic [1:0] a_rsw, b_rsw;
  logic a_sa, a_sb, a_pcs, a_tgt, a_rs0, a_rwm, a_mwm, a_rww, a_illw, a_seen;
  logic b_sa, b_sb, b_pcs, b_tgt, b_rs0, b_rwm, b_mwm, b_rww, b_illw, b_seen;

  always #5 clk = ~clk;

  pipe_ctrl_v2 #(.ALUC_W(4), .EN_JALR(1'b1), .EN_UPPER(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(a_imm), .ALUControlE(a_alu), .ALUSrcAE(a_sa), .ALUSrcBE(a_sb),
    .PCSrcE(a_pcs), .PCTargetSrcE(a_tgt), .ResultSrcE0(a_rs0), .RegWriteM(a_rwm),
    .MemWriteM(a_mwm), .Funct3M(a_f3m), .ResultSrcW(a_rsw), .RegWriteW(a_rww),
    .IllegalW(a_illw), .IllegalSeen(a_seen));

  pipe_ctrl_v2 #(.ALUC_W(4), .EN_JALR(1'b0), .EN_UPPER(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(b_imm), .ALUControlE(b_alu), .ALUSrcAE(b_sa), .ALUSrcBE(b_sb),
    .PCSrcE(b_pcs), .PCTargetSrcE(b_tgt), .ResultSrcE0(b_rs0), .RegWriteM(b_rwm),
    .MemWriteM(b_mwm), .Funct3M(b_f3m), .ResultSrcW(b_rsw), .RegWriteW(b_rww),
    .IllegalW(b_illw), .IllegalSeen(b_seen));

  typedef struct packed {
    logic [2:0] imm; logic [3:0] alu;
    logic sa, sb, pcs, tgt, rs0, rwm, mwm;
    logic [2:0] f3m; logic [1:0] rsw; logic rww, illw, seen;
  } obs_t;

  obs_t a_obs, b_obs;
  assign a_obs = {a_imm, a_alu, a_sa, a_sb, a_pcs, a_tgt, a_rs0, a_rwm, a_mwm,
                  a_f3m, a_rsw, a_rww, a_illw, a_seen};
  assign b_obs = {b_imm, b_alu, b_sa, b_sb, b_pcs, b_tgt, b_rs0, b_rwm, b_mwm,
                  b_f3m, b_rsw, b_rww, b_illw, b_seen};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, ".ImmSrcD"},      8'(act.imm),  8'(exp.imm));
    chk({tag, ".ALUControlE"},  8'(act.alu),  8'(exp.alu));
    chk({tag, ".ALUSrcAE"},     8'(act.sa),   8'(exp.sa));
    chk({tag, ".ALUSrcBE"},     8'(act.sb),   8'(exp.sb));
    chk({tag, ".PCSrcE"},       8'(act.pcs),  8'(exp.pcs));
    chk({tag, ".PCTargetSrcE"}, 8'(act.tgt),  8'(exp.tgt));
    chk({tag, ".ResultSrcE0"},  8'(act.rs0),  8'(exp.rs0));
    chk({tag, ".RegWriteM"},    8'(act.rwm),  8'(exp.rwm));
    chk({tag, ".MemWriteM"},    8'(act.mwm),  8'(exp.mwm));
    chk({tag, ".Funct3M"},      8'(act.f3m),  8'(exp.f3m));
    chk({tag, ".ResultSrcW"},   8'(act.rsw),  8'(exp.rsw));
    chk({tag, ".RegWriteW"},    8'(act.rww),  8'(exp.rww));
    chk({tag, ".IllegalW"},     8'(act.illw), 8'(exp.illw));
    chk({tag, ".IllegalSeen"},  8'(act.seen), 8'(exp.seen));
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] imm; logic rw; logic [1:0] rs; logic mw, jmp, br;
    logic [3:0] alu; logic sa, sb, tgt; logic [2:0] f3; logic ill;
  } mctl_t;

  function automatic mctl_t ref_dec(input logic [6:0] o, input logic [2:0] f,
                                    input logic f7, input bit en_j, input bit en_u);
    mctl_t c;
    bit ok;
    logic [3:0] alu_by_f3 [8];
    // funct3 -> add sll slt sltu xor srl or and
    alu_by_f3 = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    c = '0;
    c.f3 = f;
    ok = 1'b1;
    case (o)
      7'b0000011: begin c.rw = 1'b1; c.rs = 2'd1; c.sb = 1'b1; ok = (f == 3'd2); end
      7'b0100011: begin c.mw = 1'b1; c.sb = 1'b1; c.imm = 3'd1; ok = (f == 3'd2); end
      7'b0110011: begin
        c.rw = 1'b1; c.alu = alu_by_f3[f];
        if (f7 && f == 3'd0) c.alu = 4'd1;
        if (f7 && f == 3'd5) c.alu = 4'd9;
      end
      7'b0010011: begin
        c.rw = 1'b1; c.sb = 1'b1; c.alu = alu_by_f3[f];
        if (f7 && f == 3'd5) c.alu = 4'd9;
      end
      7'b1100011: begin c.br = 1'b1; c.alu = 4'd1; c.imm = 3'd2; ok = (f != 3'd2) && (f != 3'd3); end
      7'b1101111: begin c.jmp = 1'b1; c.rw = 1'b1; c.rs = 2'd2; c.imm = 3'd3; end
      7'b1100111: begin c.jmp = 1'b1; c.rw = 1'b1; c.rs = 2'd2; c.sb = 1'b1; c.tgt = 1'b1; ok = en_j; end
      7'b0110111: begin c.rw = 1'b1; c.sb = 1'b1; c.alu = 4'd10; c.imm = 3'd4; ok = en_u; end
      7'b0010111: begin c.rw = 1'b1; c.sa = 1'b1; c.sb = 1'b1; c.imm = 3'd4; ok = en_u; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin c.rw = 1'b0; c.mw = 1'b0; c.br = 1'b0; c.jmp = 1'b0; c.ill = 1'b1; end
    return c;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f, input logic z,
                                     input logic lt, input logic ltu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  mctl_t me [2];
  mctl_t mm [2];
  mctl_t mw [2];
  logic  mseen [2];

  function automatic obs_t model_obs(input int k);
    obs_t o;
    mctl_t d;
    d = ref_dec(op, funct3, funct7b5, k == 0, k == 0);
    o.imm  = d.imm;
    o.alu  = me[k].alu;
    o.sa   = me[k].sa;
    o.sb   = me[k].sb;
    o.pcs  = (me[k].br & ref_taken(me[k].f3, ZeroE, LtE, LtuE)) | me[k].jmp;
    o.tgt  = me[k].tgt;
    o.rs0  = me[k].rs[0];
    o.rwm  = mm[k].rw;
    o.mwm  = mm[k].mw;
    o.f3m  = mm[k].f3;
    o.rsw  = mw[k].rs;
    o.rww  = mw[k].rw;
    o.illw = mw[k].ill;
    o.seen = mseen[k];
    return o;
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge,
  // then step off the edge before anything is sampled.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        me[k] = '0; mm[k] = '0; mw[k] = '0; mseen[k] = 1'b0;
      end else begin
        mseen[k] = mseen[k] | mw[k].ill;
        mw[k] = mm[k];
        mm[k] = (StallE && !FlushE) ? '0 : me[k];
        if (FlushE) me[k] = '0;
        else if (!StallE) me[k] = ref_dec(op, funct3, funct7b5, k == 0, k == 0);
      end
    end
    #1;
  endtask

  task automatic drv(input logic [6:0] o, input logic [2:0] f, input logic f7);
    op = o; funct3 = f; funct7b5 = f7;
  endtask

  // ---------------- directed vector table ----------------
  // flg = {funct7b5, ZeroE, LtE, LtuE}; e = {SrcA, SrcB, PCSrc, TgtSrc, ResSrc0}
  // m = {RegWriteM, MemWriteM}; w = {ResultSrcW, RegWriteW, IllegalW}
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [3:0] flg;
    logic [2:0] imm; logic [3:0] alu; logic [4:0] e; logic [1:0] m; logic [3:0] w;
    string nm;
  } vec_t;

  vec_t vt [22];

  initial begin
    vt[0]  = '{7'b0110011, 3'b000, 4'b0000, 3'b000, 4'b0000, 5'b00000, 2'b10, 4'b0010, "add"};
    vt[1]  = '{7'b0110011, 3'b000, 4'b1000, 3'b000, 4'b0001, 5'b00000, 2'b10, 4'b0010, "sub"};
    vt[2]  = '{7'b0110011, 3'b101, 4'b1000, 3'b000, 4'b1001, 5'b00000, 2'b10, 4'b0010, "sra"};
    vt[3]  = '{7'b0110011, 3'b101, 4'b0000, 3'b000, 4'b1000, 5'b00000, 2'b10, 4'b0010, "srl"};
    vt[4]  = '{7'b0010011, 3'b101, 4'b1000, 3'b000, 4'b1001, 5'b01000, 2'b10, 4'b0010, "srai"};
    vt[5]  = '{7'b0010011, 3'b000, 4'b1000, 3'b000, 4'b0000, 5'b01000, 2'b10, 4'b0010, "addi_b30"};
    vt[6]  = '{7'b0110011, 3'b011, 4'b0000, 3'b000, 4'b0110, 5'b00000, 2'b10, 4'b0010, "sltu"};
    vt[7]  = '{7'b0010011, 3'b111, 4'b0000, 3'b000, 4'b0010, 5'b01000, 2'b10, 4'b0010, "andi"};
    vt[8]  = '{7'b0000011, 3'b010, 4'b0000, 3'b000, 4'b0000, 5'b01001, 2'b10, 4'b0110, "lw"};
    vt[9]  = '{7'b0100011, 3'b010, 4'b0000, 3'b001, 4'b0000, 5'b01000, 2'b01, 4'b0000, "sw"};
    vt[10] = '{7'b1100011, 3'b001, 4'b0000, 3'b010, 4'b0001, 5'b00100, 2'b00, 4'b0000, "bne_z0"};
    vt[11] = '{7'b1100011, 3'b001, 4'b0100, 3'b010, 4'b0001, 5'b00000, 2'b00, 4'b0000, "bne_z1"};
    vt[12] = '{7'b1100011, 3'b110, 4'b0001, 3'b010, 4'b0001, 5'b00100, 2'b00, 4'b0000, "bltu_t"};
    vt[13] = '{7'b1100011, 3'b101, 4'b0010, 3'b010, 4'b0001, 5'b00000, 2'b00, 4'b0000, "bge_nt"};
    vt[14] = '{7'b1100011, 3'b000, 4'b0100, 3'b010, 4'b0001, 5'b00100, 2'b00, 4'b0000, "beq_t"};
    vt[15] = '{7'b1101111, 3'b000, 4'b0000, 3'b011, 4'b0000, 5'b00100, 2'b10, 4'b1010, "jal"};
    vt[16] = '{7'b1100111, 3'b000, 4'b0000, 3'b000, 4'b0000, 5'b01110, 2'b10, 4'b1010, "jalr"};
    vt[17] = '{7'b0110111, 3'b000, 4'b0000, 3'b100, 4'b1010, 5'b01000, 2'b10, 4'b0010, "lui"};
    vt[18] = '{7'b0010111, 3'b000, 4'b0000, 3'b100, 4'b0000, 5'b11000, 2'b10, 4'b0010, "auipc"};
    vt[19] = '{7'b1111111, 3'b000, 4'b0000, 3'b000, 4'b0000, 5'b00000, 2'b00, 4'b0001, "bad_op"};
    vt[20] = '{7'b0000011, 3'b000, 4'b0000, 3'b000, 4'b0000, 5'b01001, 2'b00, 4'b0101, "lb_ill"};
    vt[21] = '{7'b1100011, 3'b010, 4'b0100, 3'b010, 4'b0001, 5'b00000, 2'b00, 4'b0001, "br010_ill"};
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      me[k] = '0; mm[k] = '0; mw[k] = '0; mseen[k] = 1'b0;
    end
    reset = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    drv(7'b0110011, 3'b000, 1'b0);
    #2;

    // Reset held two cycles, then first instruction latency.
    for (int i = 0; i < 2; i++) begin
      tick();
      check_obs("rst", a_obs, '0);
      check_obs("rst_nj", b_obs, '0);
    end
    reset = 1'b1;
    drv(7'b0110011, 3'b000, 1'b1);
    tick();
    chk("lat.ALUControlE", 8'(a_alu), 8'd1);
    chk("lat.RegWriteM_c1", 8'(a_rwm), 8'd0);
    drv(NOP_OP, 3'b000, 1'b0);
    tick();
    chk("lat.RegWriteM", 8'(a_rwm), 8'd1);
    chk("lat.RegWriteW_c2", 8'(a_rww), 8'd0);
    tick();
    chk("lat.RegWriteW", 8'(a_rww), 8'd1);
    chk("lat.ResultSrcW", 8'(a_rsw), 8'd0);

    // Directed table, each instruction followed by nops.
    for (int i = 0; i < 22; i++) begin
      {funct7b5, ZeroE, LtE, LtuE} = vt[i].flg;
      op = vt[i].op; funct3 = vt[i].f3;
      #1;
      chk({vt[i].nm, ".ImmSrcD"}, 8'(a_imm), 8'(vt[i].imm));
      tick();
      drv(NOP_OP, 3'b000, 1'b0);
      #1;
      chk({vt[i].nm, ".ALUControlE"}, 8'(a_alu), 8'(vt[i].alu));
      chk({vt[i].nm, ".Ectl"}, 8'({a_sa, a_sb, a_pcs, a_tgt, a_rs0}), 8'(vt[i].e));
      tick();
      chk({vt[i].nm, ".Mctl"}, 8'({a_rwm, a_mwm}), 8'(vt[i].m));
      chk({vt[i].nm, ".Funct3M"}, 8'(a_f3m), 8'(vt[i].f3));
      tick();
      chk({vt[i].nm, ".Wctl"}, 8'({a_rsw, a_rww, a_illw}), 8'(vt[i].w));
    end
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;

    // Stall with lw in E.
    drv(7'b0000011, 3'b010, 1'b0);
    tick();
    drv(7'b0110011, 3'b000, 1'b0);
    StallE = 1'b1;
    tick();
    chk("stall.ALUControlE", 8'(a_alu), 8'd0);
    chk("stall.ALUSrcBE", 8'(a_sb), 8'd1);
    chk("stall.ResultSrcE0", 8'(a_rs0), 8'd1);
    chk("stall.RegWriteM", 8'(a_rwm), 8'd0);
    StallE = 1'b0;
    tick();
    chk("stall_rel.RegWriteM", 8'(a_rwm), 8'd1);
    chk("stall_rel.Funct3M", 8'(a_f3m), 8'd2);
    chk("stall_rel.ALUSrcBE", 8'(a_sb), 8'd0);
    tick();
    chk("stall_rel.ResultSrcW", 8'(a_rsw), 8'd1);

    // Stall and flush together with jal in E.
    drv(7'b1101111, 3'b000, 1'b0);
    tick();
    drv(7'b0110011, 3'b000, 1'b1);
    StallE = 1'b1; FlushE = 1'b1;
    #1;
    chk("sf.PCSrcE_before", 8'(a_pcs), 8'd1);
    tick();
    chk("sf.ALUControlE", 8'(a_alu), 8'd0);
    chk("sf.PCSrcE", 8'(a_pcs), 8'd0);
    chk("sf.RegWriteM", 8'(a_rwm), 8'd1);
    StallE = 1'b0; FlushE = 1'b0;
    tick();
    chk("sf.ResultSrcW", 8'(a_rsw), 8'd2);
    chk("sf.RegWriteW", 8'(a_rww), 8'd1);
    chk("sf.ALUControlE_next", 8'(a_alu), 8'd1);

    // Illegal retires once; sticky flag until reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drv(7'b1111111, 3'b000, 1'b0);
    tick();
    drv(NOP_OP, 3'b000, 1'b0);
    chk("ill.IllegalW_c1", 8'(a_illw), 8'd0);
    tick();
    chk("ill.IllegalW_c2", 8'(a_illw), 8'd0);
    tick();
    chk("ill.IllegalW_c3", 8'(a_illw), 8'd1);
    chk("ill.RegWriteW_c3", 8'(a_rww), 8'd0);
    chk("ill.IllegalSeen_c3", 8'(a_seen), 8'd0);
    tick();
    chk("ill.IllegalW_c4", 8'(a_illw), 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ill.IllegalSeen_hold", 8'(a_seen), 8'd1);
      tick();
    end
    reset = 1'b0;
    tick();
    chk("ill.IllegalSeen_rst", 8'(a_seen), 8'd0);
    reset = 1'b1;

    // jalr on both configurations.
    drv(7'b1100111, 3'b000, 1'b0);
    tick();
    drv(NOP_OP, 3'b000, 1'b0);
    #1;
    chk("jalr.PCSrcE", 8'(a_pcs), 8'd1);
    chk("jalr.PCTargetSrcE", 8'(a_tgt), 8'd1);
    chk("jalr_nj.PCSrcE", 8'(b_pcs), 8'd0);
    tick();
    tick();
    chk("jalr.ResultSrcW", 8'(a_rsw), 8'd2);
    chk("jalr.RegWriteW", 8'(a_rww), 8'd1);
    chk("jalr_nj.IllegalW", 8'(b_illw), 8'd1);
    chk("jalr_nj.RegWriteW", 8'(b_rww), 8'd0);

    // Randomized run against the reference model, both configurations.
    begin
      logic [6:0] ops [11];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};
      for (int cyc = 0; cyc < 2000; cyc++) begin
        op       = ops[$urandom_range(0, 10)];
        funct3   = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
        ZeroE    = 1'($urandom_range(0, 1));
        LtE      = 1'($urandom_range(0, 1));
        LtuE     = 1'($urandom_range(0, 1));
        StallE   = ($urandom_range(0, 5) == 0);
        FlushE   = ($urandom_range(0, 7) == 0);
        reset    = ($urandom_range(0, 49) != 0);
        #1;
        check_obs("rnd", a_obs, model_obs(0));
        check_obs("rnd_nj", b_obs, model_obs(1));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
